// File: rtl/umi_fifo_mc_pkg.sv
// Shared constants and sizing helpers for the multi-channel UMI FIFO.
package umi_fifo_mc_pkg;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int unsigned entry_width(input int unsigned cw,
                                                input int unsigned aw,
                                                input int unsigned dw);
        return cw + 2 * aw + dw;
    endfunction

    function automatic int unsigned cntw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/umi_fifo_mc_chan.sv
// Single-channel show-ahead sync FIFO with occupancy and full/empty/almost-full flags.
module umi_fifo_mc_chan
    import umi_fifo_mc_pkg::*;
#(
    parameter int unsigned EW    = 288,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AFULL = 2,
    localparam int unsigned CNTW = cntw(DEPTH)
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [EW-1:0]   i_wdata,
    output logic [EW-1:0]   o_rdata,
    output logic [CNTW-1:0] o_count,
    output logic            o_full,
    output logic            o_empty,
    output logic            o_afull
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [EW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CNTW-1:0] r_count;
    logic            w_push;
    logic            w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Pointers wrap naturally; count tracks occupancy independently of them
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNTW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_afull = (32'(DEPTH) - 32'(r_count)) <= 32'(AFULL);

endmodule

// File: rtl/umi_fifo_mc.sv
// Multi-channel UMI FIFO: per-channel buffers merged by a round-robin arbiter,
// with optional zero-latency bypass and LFSR-driven input backpressure.
module umi_fifo_mc
    import umi_fifo_mc_pkg::*;
#(
    parameter int unsigned NCH    = 4,
    parameter int unsigned DW     = 128,
    parameter int unsigned AW     = 64,
    parameter int unsigned CW     = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AFULL  = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned CNTW  = cntw(DEPTH)
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                bypass,
    input  logic                chaosmode,
    input  logic [NCH-1:0]      umi_in_valid,
    input  logic [NCH*CW-1:0]   umi_in_cmd,
    input  logic [NCH*AW-1:0]   umi_in_dstaddr,
    input  logic [NCH*AW-1:0]   umi_in_srcaddr,
    input  logic [NCH*DW-1:0]   umi_in_data,
    output logic [NCH-1:0]      umi_in_ready,
    output logic                umi_out_valid,
    output logic [CW-1:0]       umi_out_cmd,
    output logic [AW-1:0]       umi_out_dstaddr,
    output logic [AW-1:0]       umi_out_srcaddr,
    output logic [DW-1:0]       umi_out_data,
    input  logic                umi_out_ready,
    output logic [NCH-1:0]      fifo_full,
    output logic [NCH-1:0]      fifo_empty,
    output logic [NCH-1:0]      fifo_afull,
    output logic [NCH*CNTW-1:0] fifo_count
);

    localparam int unsigned EW = entry_width(CW, AW, DW);
    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [15:0]    r_lfsr;
    logic           r_run;
    arb_state_t     r_state;
    arb_state_t     w_state_nxt;
    logic [IW-1:0]  r_rr;
    logic [IW-1:0]  r_lock_idx;
    logic [IW-1:0]  w_rr_idx;
    logic [IW-1:0]  w_gnt_idx;
    logic           w_byp;
    logic           w_chaos_block;
    logic           w_out_valid;
    logic           w_handshake;
    logic [NCH-1:0] w_req;
    logic [NCH-1:0] w_push;
    logic [NCH-1:0] w_pop;
    logic [EW-1:0]  w_head   [NCH];
    logic [EW-1:0]  w_in_ent [NCH];
    logic [EW-1:0]  w_out_ent;

    assign w_byp         = (BYPASS != 0) ? bypass : 1'b0;
    assign w_chaos_block = chaosmode & r_lfsr[0];

    // r_run keeps ready/valid low until the first clock after reset release
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_lfsr <= LFSR_SEED;
            r_run  <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
            r_run  <= 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        assign w_in_ent[g] = {umi_in_cmd[g*CW +: CW], umi_in_dstaddr[g*AW +: AW],
                              umi_in_srcaddr[g*AW +: AW], umi_in_data[g*DW +: DW]};
        assign w_push[g]   = umi_in_valid[g] & umi_in_ready[g] & ~w_byp;
        assign w_pop[g]    = w_handshake & ~w_byp & (w_gnt_idx == IW'(g));

        umi_fifo_mc_chan #(
            .EW    (EW),
            .DEPTH (DEPTH),
            .AFULL (AFULL)
        ) u_chan (
            .clk     (clk),
            .nreset  (nreset),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_wdata (w_in_ent[g]),
            .o_rdata (w_head[g]),
            .o_count (fifo_count[g*CNTW +: CNTW]),
            .o_full  (fifo_full[g]),
            .o_empty (fifo_empty[g]),
            .o_afull (fifo_afull[g])
        );
    end

    assign w_req = w_byp ? umi_in_valid : ~fifo_empty;

    // First requester at or after the rr pointer, searching upward modulo NCH
    always_comb begin
        w_rr_idx = r_rr;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_req[IW'((int'(r_rr) + k) % int'(NCH))]) begin
                w_rr_idx = IW'((int'(r_rr) + k) % int'(NCH));
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_state <= ARB_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Stalled output freezes the grant so valid and payload stay stable
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_idx   = w_rr_idx;
        w_out_valid = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                w_out_valid = r_run & (|w_req) & ~(w_byp & w_chaos_block);
                if (w_out_valid & ~umi_out_ready) w_state_nxt = ARB_LOCKED;
            end
            ARB_LOCKED: begin
                w_gnt_idx   = r_lock_idx;
                w_out_valid = r_run & w_req[r_lock_idx];
                if (umi_out_ready) w_state_nxt = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    assign w_handshake = w_out_valid & umi_out_ready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rr       <= '0;
            r_lock_idx <= '0;
        end else begin
            if (r_state == ARB_IDLE) r_lock_idx <= w_gnt_idx;
            if (w_handshake) begin
                r_rr <= (w_gnt_idx == IW'(NCH - 1)) ? '0 : w_gnt_idx + IW'(1);
            end
        end
    end

    // Bypass ready mirrors the output handshake so nothing is consumed twice
    always_comb begin
        umi_in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_byp) umi_in_ready[i] = w_handshake & (w_gnt_idx == IW'(i));
            else       umi_in_ready[i] = r_run & ~fifo_full[i] & ~w_chaos_block;
        end
    end

    assign w_out_ent     = w_byp ? w_in_ent[w_gnt_idx] : w_head[w_gnt_idx];
    assign umi_out_valid = w_out_valid;
    assign {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data} = w_out_ent;

endmodule

// File: tb/tb_umi_fifo_mc.sv
// Bench for umi_fifo_mc: directed scenarios plus randomized chaos traffic against a queue model.
module tb_umi_fifo_mc;

    localparam int NCH   = 4;
    localparam int DW    = 128;
    localparam int AW    = 64;
    localparam int CW    = 32;
    localparam int DEPTH = 4;
    localparam int AFULL = 2;
    localparam int CNTW  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
    } ent_t;

    logic                clk;
    logic                nreset;
    logic                bypass;
    logic                chaosmode;
    logic [NCH-1:0]      umi_in_valid;
    logic [NCH*CW-1:0]   umi_in_cmd;
    logic [NCH*AW-1:0]   umi_in_dstaddr;
    logic [NCH*AW-1:0]   umi_in_srcaddr;
    logic [NCH*DW-1:0]   umi_in_data;
    logic [NCH-1:0]      umi_in_ready;
    logic                umi_out_valid;
    logic [CW-1:0]       umi_out_cmd;
    logic [AW-1:0]       umi_out_dstaddr;
    logic [AW-1:0]       umi_out_srcaddr;
    logic [DW-1:0]       umi_out_data;
    logic                umi_out_ready;
    logic [NCH-1:0]      fifo_full;
    logic [NCH-1:0]      fifo_empty;
    logic [NCH-1:0]      fifo_afull;
    logic [NCH*CNTW-1:0] fifo_count;

    int total;
    int bad;

    ent_t q [NCH][$];

    umi_fifo_mc #(
        .NCH(NCH), .DW(DW), .AW(AW), .CW(CW),
        .DEPTH(DEPTH), .AFULL(AFULL), .BYPASS(1)
    ) dut (
        .clk             (clk),
        .nreset          (nreset),
        .bypass          (bypass),
        .chaosmode       (chaosmode),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .fifo_afull      (fifo_afull),
        .fifo_count      (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ent_t rand_ent(input int ch, input int seq);
        ent_t e;
        e.cmd  = $urandom;
        e.dst  = {$urandom, $urandom};
        e.src  = {$urandom, $urandom};
        e.data = {$urandom, $urandom, $urandom, $urandom};
        e.data[127:120] = 8'(ch);
        e.data[31:0]    = 32'(seq);
        return e;
    endfunction

    function automatic ent_t get_out();
        return {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data};
    endfunction

    function automatic logic [CNTW-1:0] get_count(input int ch);
        return fifo_count[ch*CNTW +: CNTW];
    endfunction

    task automatic set_in(input int ch, input ent_t e);
        umi_in_cmd[ch*CW +: CW]     = e.cmd;
        umi_in_dstaddr[ch*AW +: AW] = e.dst;
        umi_in_srcaddr[ch*AW +: AW] = e.src;
        umi_in_data[ch*DW +: DW]    = e.data;
    endtask

    task automatic clear_inputs();
        bypass         = 1'b0;
        chaosmode      = 1'b0;
        umi_in_valid   = '0;
        umi_in_cmd     = '0;
        umi_in_dstaddr = '0;
        umi_in_srcaddr = '0;
        umi_in_data    = '0;
        umi_out_ready  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        nreset = 1'b0;
        bypass = 1'b1;
        umi_out_ready = 1'b1;
        for (int c = 0; c < NCH; c++) set_in(c, rand_ent(c, 0));
        umi_in_valid = '1;
        #1;
        total++; if (umi_in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", umi_in_ready); end
        total++; if (umi_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", umi_out_valid); end
        total++; if (fifo_empty !== 4'b1111) begin bad++; $display("FAIL reset_empty got=%b exp=1111", fifo_empty); end
        total++; if (fifo_full !== 4'b0000) begin bad++; $display("FAIL reset_full got=%b exp=0000", fifo_full); end
        total++; if (fifo_afull !== 4'b0000) begin bad++; $display("FAIL reset_afull got=%b exp=0000", fifo_afull); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL reset_count got=%h exp=0", fifo_count); end
        @(negedge clk);
        clear_inputs();
        nreset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill_drain();
        ent_t e [5];
        do_reset();
        for (int k = 0; k < 5; k++) e[k] = rand_ent(0, k);
        for (int k = 0; k < DEPTH; k++) begin
            set_in(0, e[k]);
            umi_in_valid = 4'b0001;
            #1;
            total++; if (umi_in_ready[0] !== 1'b1) begin bad++; $display("FAIL fill_ready k=%0d got=%b exp=1", k, umi_in_ready[0]); end
            @(negedge clk);
            total++; if (get_count(0) !== CNTW'(k + 1)) begin bad++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, get_count(0), k + 1); end
            total++; if (fifo_afull[0] !== ((DEPTH - (k + 1)) <= AFULL)) begin bad++; $display("FAIL fill_afull k=%0d got=%b", k, fifo_afull[0]); end
            total++; if (fifo_full[0] !== (k + 1 == DEPTH)) begin bad++; $display("FAIL fill_full k=%0d got=%b", k, fifo_full[0]); end
        end
        set_in(0, e[4]);
        #1;
        total++; if (umi_in_ready[0] !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", umi_in_ready[0]); end
        umi_in_valid = '0;
        @(negedge clk);
        total++; if (get_count(0) !== CNTW'(DEPTH)) begin bad++; $display("FAIL full_hold_count got=%0d exp=%0d", get_count(0), DEPTH); end
        umi_out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            total++; if (umi_out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid k=%0d got=%b exp=1", k, umi_out_valid); end
            total++; if (get_out() !== e[k]) begin bad++; $display("FAIL drain_data k=%0d got=%h exp=%h", k, get_out(), e[k]); end
            @(negedge clk);
        end
        #1;
        total++; if (fifo_empty[0] !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", fifo_empty[0]); end
        total++; if (umi_out_valid !== 1'b0) begin bad++; $display("FAIL drain_idle_valid got=%b exp=0", umi_out_valid); end
        umi_out_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        ent_t e [NCH][2];
        do_reset();
        for (int j = 0; j < 2; j++) begin
            for (int c = 0; c < NCH; c++) begin
                e[c][j] = rand_ent(c, j);
                set_in(c, e[c][j]);
            end
            umi_in_valid = '1;
            #1;
            total++; if (umi_in_ready !== 4'b1111) begin bad++; $display("FAIL rr_fill_ready got=%b exp=1111", umi_in_ready); end
            @(negedge clk);
        end
        umi_in_valid = '0;
        umi_out_ready = 1'b1;
        for (int n = 0; n < 2 * NCH; n++) begin
            #1;
            total++; if (umi_out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid n=%0d got=%b exp=1", n, umi_out_valid); end
            total++; if (get_out() !== e[n % NCH][n / NCH]) begin bad++; $display("FAIL rr_order n=%0d got_ch=%0d exp_ch=%0d", n, umi_out_data[127:120], n % NCH); end
            @(negedge clk);
        end
        #1;
        total++; if (fifo_empty !== 4'b1111) begin bad++; $display("FAIL rr_end_empty got=%b exp=1111", fifo_empty); end
        umi_out_ready = 1'b0;
    endtask

    task automatic test_stall_lock();
        ent_t e0, e1, e2;
        do_reset();
        e0 = rand_ent(0, 0);
        e1 = rand_ent(1, 0);
        e2 = rand_ent(2, 0);
        set_in(1, e1);
        umi_in_valid = 4'b0010;
        @(negedge clk);
        set_in(0, e0);
        set_in(2, e2);
        umi_in_valid = 4'b0101;
        for (int n = 0; n < 4; n++) begin
            #1;
            total++; if (umi_out_valid !== 1'b1) begin bad++; $display("FAIL lock_valid n=%0d got=%b exp=1", n, umi_out_valid); end
            total++; if (get_out() !== e1) begin bad++; $display("FAIL lock_hold n=%0d got=%h exp=%h", n, get_out(), e1); end
            @(negedge clk);
            umi_in_valid = '0;
        end
        umi_out_ready = 1'b1;
        #1;
        total++; if (get_out() !== e1) begin bad++; $display("FAIL lock_release got=%h exp=%h", get_out(), e1); end
        @(negedge clk);
        #1;
        total++; if (get_out() !== e2) begin bad++; $display("FAIL lock_next_ch2 got_ch=%0d exp_ch=2", umi_out_data[127:120]); end
        @(negedge clk);
        #1;
        total++; if (get_out() !== e0) begin bad++; $display("FAIL lock_then_ch0 got_ch=%0d exp_ch=0", umi_out_data[127:120]); end
        @(negedge clk);
        #1;
        total++; if (umi_out_valid !== 1'b0) begin bad++; $display("FAIL lock_end_valid got=%b exp=0", umi_out_valid); end
        umi_out_ready = 1'b0;
    endtask

    task automatic test_push_pop_full();
        ent_t e [5];
        do_reset();
        for (int k = 0; k < 5; k++) e[k] = rand_ent(2, k);
        for (int k = 0; k < DEPTH; k++) begin
            set_in(2, e[k]);
            umi_in_valid = 4'b0100;
            @(negedge clk);
        end
        set_in(2, e[4]);
        umi_out_ready = 1'b1;
        #1;
        total++; if (get_count(2) !== CNTW'(DEPTH)) begin bad++; $display("FAIL ppf_count_full got=%0d exp=%0d", get_count(2), DEPTH); end
        total++; if (umi_in_ready[2] !== 1'b0) begin bad++; $display("FAIL ppf_push_blocked got=%b exp=0", umi_in_ready[2]); end
        total++; if (get_out() !== e[0]) begin bad++; $display("FAIL ppf_head got=%h exp=%h", get_out(), e[0]); end
        @(negedge clk);
        umi_out_ready = 1'b0;
        total++; if (get_count(2) !== CNTW'(DEPTH - 1)) begin bad++; $display("FAIL ppf_count_after_pop got=%0d exp=%0d", get_count(2), DEPTH - 1); end
        #1;
        total++; if (umi_in_ready[2] !== 1'b1) begin bad++; $display("FAIL ppf_ready_again got=%b exp=1", umi_in_ready[2]); end
        @(negedge clk);
        umi_in_valid = '0;
        total++; if (get_count(2) !== CNTW'(DEPTH)) begin bad++; $display("FAIL ppf_refill got=%0d exp=%0d", get_count(2), DEPTH); end
        umi_out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            #1;
            total++; if (get_out() !== e[k]) begin bad++; $display("FAIL ppf_order k=%0d got=%h exp=%h", k, get_out(), e[k]); end
            @(negedge clk);
        end
        umi_out_ready = 1'b0;
    endtask

    task automatic test_bypass();
        ent_t e;
        do_reset();
        e = rand_ent(3, 0);
        e.data = 128'hDEAD_BEEF;
        bypass = 1'b1;
        set_in(3, e);
        umi_in_valid = 4'b1000;
        umi_out_ready = 1'b1;
        #1;
        total++; if (umi_out_valid !== 1'b1) begin bad++; $display("FAIL byp_valid got=%b exp=1", umi_out_valid); end
        total++; if (umi_out_data !== 128'hDEAD_BEEF) begin bad++; $display("FAIL byp_data got=%h exp=deadbeef", umi_out_data); end
        total++; if (umi_out_cmd !== e.cmd) begin bad++; $display("FAIL byp_cmd got=%h exp=%h", umi_out_cmd, e.cmd); end
        total++; if (umi_in_ready !== 4'b1000) begin bad++; $display("FAIL byp_ready got=%b exp=1000", umi_in_ready); end
        @(negedge clk);
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL byp_count got=%h exp=0", fifo_count); end
        umi_out_ready = 1'b0;
        #1;
        total++; if (umi_in_ready[3] !== 1'b0) begin bad++; $display("FAIL byp_stall_ready got=%b exp=0", umi_in_ready[3]); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_chaos();
        ent_t           pend [NCH];
        logic [NCH-1:0] has_pend;
        int             sz [NCH];
        int             seq, m_rr, m_lock_ch, exp_ch, idx, suppressed, accepted;
        bit             m_locked, exp_valid;
        logic           ref_ready;
        bit             ref_set;
        do_reset();
        for (int c = 0; c < NCH; c++) q[c].delete();
        has_pend   = '0;
        seq        = 0;
        m_rr       = 0;
        m_locked   = 0;
        m_lock_ch  = 0;
        suppressed = 0;
        accepted   = 0;
        chaosmode  = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc == 1000) begin
                nreset = 1'b0;
                #1;
                total++; if (umi_in_ready !== 4'b0000) begin bad++; $display("FAIL midrst_ready got=%b exp=0000", umi_in_ready); end
                total++; if (umi_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", umi_out_valid); end
                total++; if (fifo_count !== '0) begin bad++; $display("FAIL midrst_count got=%h exp=0", fifo_count); end
                total++; if (fifo_empty !== 4'b1111) begin bad++; $display("FAIL midrst_empty got=%b exp=1111", fifo_empty); end
                for (int c = 0; c < NCH; c++) q[c].delete();
                has_pend = '0;
                m_rr     = 0;
                m_locked = 0;
                @(negedge clk);
                nreset = 1'b1;
                @(negedge clk);
            end
            for (int c = 0; c < NCH; c++) begin
                if (!has_pend[c] && $urandom_range(0, 1) != 0) begin
                    pend[c] = rand_ent(c, seq);
                    seq++;
                    has_pend[c] = 1'b1;
                end
                if (has_pend[c]) set_in(c, pend[c]);
            end
            umi_in_valid  = has_pend;
            umi_out_ready = ($urandom_range(0, 9) < 7);
            #1;
            ref_set = 0;
            ref_ready = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                sz[c] = q[c].size();
                total++; if (get_count(c) !== CNTW'(sz[c])) begin bad++; $display("FAIL chaos_count cyc=%0d ch=%0d got=%0d exp=%0d", cyc, c, get_count(c), sz[c]); end
                total++; if (fifo_empty[c] !== (sz[c] == 0)) begin bad++; $display("FAIL chaos_empty cyc=%0d ch=%0d got=%b", cyc, c, fifo_empty[c]); end
                total++; if (fifo_full[c] !== (sz[c] == DEPTH)) begin bad++; $display("FAIL chaos_full cyc=%0d ch=%0d got=%b", cyc, c, fifo_full[c]); end
                total++; if (fifo_afull[c] !== ((DEPTH - sz[c]) <= AFULL)) begin bad++; $display("FAIL chaos_afull cyc=%0d ch=%0d got=%b", cyc, c, fifo_afull[c]); end
                if (sz[c] == DEPTH) begin
                    total++; if (umi_in_ready[c] !== 1'b0) begin bad++; $display("FAIL chaos_ready_when_full cyc=%0d ch=%0d got=%b exp=0", cyc, c, umi_in_ready[c]); end
                end else if (!ref_set) begin
                    ref_set = 1;
                    ref_ready = umi_in_ready[c];
                end else begin
                    total++; if (umi_in_ready[c] !== ref_ready) begin bad++; $display("FAIL chaos_ready_uniform cyc=%0d ch=%0d got=%b exp=%b", cyc, c, umi_in_ready[c], ref_ready); end
                end
            end
            exp_valid = 0;
            exp_ch    = 0;
            if (m_locked) begin
                exp_valid = 1;
                exp_ch    = m_lock_ch;
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    idx = (m_rr + k) % NCH;
                    if (sz[idx] != 0) begin
                        exp_valid = 1;
                        exp_ch    = idx;
                        break;
                    end
                end
            end
            total++; if (umi_out_valid !== exp_valid) begin bad++; $display("FAIL chaos_out_valid cyc=%0d got=%b exp=%b", cyc, umi_out_valid, exp_valid); end
            if (exp_valid) begin
                total++; if (get_out() !== q[exp_ch][0]) begin bad++; $display("FAIL chaos_out_data cyc=%0d ch=%0d got=%h exp=%h", cyc, exp_ch, get_out(), q[exp_ch][0]); end
                if (umi_out_ready) begin
                    void'(q[exp_ch].pop_front());
                    m_rr     = (exp_ch + 1) % NCH;
                    m_locked = 0;
                end else begin
                    m_locked  = 1;
                    m_lock_ch = exp_ch;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (has_pend[c] && umi_in_ready[c]) begin
                    q[c].push_back(pend[c]);
                    has_pend[c] = 1'b0;
                    accepted++;
                end else if (has_pend[c] && sz[c] < DEPTH) begin
                    suppressed++;
                end
            end
            @(negedge clk);
        end
        total++; if (suppressed == 0) begin bad++; $display("FAIL chaos_backpressure got=%0d exp=nonzero", suppressed); end
        total++; if (accepted < 500) begin bad++; $display("FAIL chaos_throughput got=%0d exp>=500", accepted); end
        clear_inputs();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        nreset = 1'b0;
        clear_inputs();
        test_reset();
        test_fill_drain();
        test_round_robin();
        test_stall_lock();
        test_push_pop_full();
        test_bypass();
        test_chaos();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
